// File: rtl/bus_defs.sv
// Shared bus field positions, codes and FSM state encoding for the
// responder-side slave core.
package bus_defs;

   localparam int START_POS = 15;
   localparam int SLAVE_HI  = 14;
   localparam int SLAVE_LO  = 13;
   localparam int RW_POS    = 12;
   localparam int ADDR_HI   = 11;

   localparam logic       STARTBIT = 1'b1;
   localparam logic [1:0] SLAVE1   = 2'b01;
   localparam logic [1:0] SLAVE2   = 2'b10;
   localparam logic [1:0] SLAVE3   = 2'b11;
   localparam logic       RW_READ  = 1'b0;
   localparam logic       RW_WRITE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ADDR_ACK   = 3'd1,
      ST_WAIT_WDATA = 3'd2,
      ST_WAIT_RREQ  = 3'd3,
      ST_WRITE_WAIT = 3'd4,
      ST_READ_WAIT  = 3'd5,
      ST_DONE       = 3'd6
   } state_t;

   function automatic logic addr_match(input logic [15:0] a, input logic [1:0] id);
      return (a[START_POS] == STARTBIT) && (a[SLAVE_HI:SLAVE_LO] == id);
   endfunction

endpackage

// File: rtl/slave_core_if.sv
// Slave-interface (si) handshake bundle between a bus master core and the
// slave core.
interface slave_core_if;
   logic [15:0] addr_from_si;
   logic        addr_req_from_si;
   logic [7:0]  write_data_from_si;
   logic        write_data_req_from_si;
   logic        read_data_req_from_si;
   logic        ok_response_to_si;
   logic [7:0]  read_data_to_si;
   logic        req_done_to_si;
   logic        busy_to_si;

   modport slave (
      input  addr_from_si, addr_req_from_si, write_data_from_si,
             write_data_req_from_si, read_data_req_from_si,
      output ok_response_to_si, read_data_to_si, req_done_to_si, busy_to_si
   );

   modport master (
      output addr_from_si, addr_req_from_si, write_data_from_si,
             write_data_req_from_si, read_data_req_from_si,
      input  ok_response_to_si, read_data_to_si, req_done_to_si, busy_to_si
   );
endinterface

// File: rtl/slave_mem.sv
// Byte-wide backing store: synchronous write, registered read of the
// currently addressed location every cycle.
module slave_mem #(
   parameter int MEM_DEPTH = 4096,
   parameter int AW        = $clog2(MEM_DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/slave_core.sv
// Responder core: decodes si address words and completes one single-byte
// read or write per address phase with programmable wait states.
//
// state         | meaning
// ST_IDLE       | waiting for a matching address request
// ST_ADDR_ACK   | ok_response high, waiting for addr_req to drop
// ST_WAIT_WDATA | write accepted, waiting for write data request
// ST_WAIT_RREQ  | read accepted, waiting for read data request
// ST_WRITE_WAIT | counting wait states, then write memory
// ST_READ_WAIT  | counting wait states, then return memory byte
// ST_DONE       | req_done high, waiting for data request to drop
module slave_core
   import bus_defs::*;
#(
   parameter logic [1:0] SLAVE_ID    = 2'b01,
   parameter int         MEM_DEPTH   = 4096,
   parameter int         WAIT_STATES = 2
) (
   input  logic          clk,
   input  logic          reset,
   slave_core_if.slave   si
);

   localparam int AW = $clog2(MEM_DEPTH);

   state_t       state;
   logic [3:0]   cnt;
   logic         rw_q;
   logic [11:0]  addr_q;
   logic [7:0]   wdata_q;
   logic [7:0]   mem_rdata;
   logic         in_range;
   logic         mem_we;

   assign in_range = ({20'd0, addr_q} < 32'(MEM_DEPTH));
   // Write strobe comes straight off state so an async reset cancels it at once
   assign mem_we   = (state == ST_WRITE_WAIT) && (cnt == 4'd0) && in_range;
   assign si.busy_to_si = (state != ST_IDLE);

   slave_mem #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (addr_q[AW-1:0]),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                 <= ST_IDLE;
         cnt                   <= 4'd0;
         rw_q                  <= 1'b0;
         addr_q                <= 12'd0;
         wdata_q               <= 8'd0;
         si.ok_response_to_si  <= 1'b0;
         si.req_done_to_si     <= 1'b0;
         si.read_data_to_si    <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (si.addr_req_from_si && addr_match(si.addr_from_si, SLAVE_ID)) begin
                  rw_q                 <= si.addr_from_si[RW_POS];
                  addr_q               <= si.addr_from_si[ADDR_HI:0];
                  si.ok_response_to_si <= 1'b1;
                  state                <= ST_ADDR_ACK;
               end
            end
            ST_ADDR_ACK: begin
               if (!si.addr_req_from_si) begin
                  si.ok_response_to_si <= 1'b0;
                  state <= (rw_q == RW_WRITE) ? ST_WAIT_WDATA : ST_WAIT_RREQ;
               end
            end
            ST_WAIT_WDATA: begin
               if (si.write_data_req_from_si) begin
                  wdata_q <= si.write_data_from_si;
                  cnt     <= 4'(WAIT_STATES);
                  state   <= ST_WRITE_WAIT;
               end
            end
            ST_WAIT_RREQ: begin
               if (si.read_data_req_from_si) begin
                  cnt   <= 4'(WAIT_STATES);
                  state <= ST_READ_WAIT;
               end
            end
            ST_WRITE_WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  si.req_done_to_si <= 1'b1;
                  state             <= ST_DONE;
               end
            end
            ST_READ_WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  // mem_rdata already reflects addr_q: it was latched cycles ago
                  si.read_data_to_si <= in_range ? mem_rdata : 8'h00;
                  si.req_done_to_si  <= 1'b1;
                  state              <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!((rw_q == RW_WRITE) ? si.write_data_req_from_si
                                        : si.read_data_req_from_si)) begin
                  si.req_done_to_si <= 1'b0;
                  state             <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_slave_core.sv
// Bench for slave_core: three instances with different ID/depth/wait-state
// settings, directed scenarios plus random traffic against a byte-array model.
module tb_slave_core;
   import bus_defs::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   always #5 clk = ~clk;

   int          sel = 0;
   logic [15:0] addr = '0;
   logic        addr_req = 1'b0;
   logic [7:0]  wdata = '0;
   logic        wreq = 1'b0;
   logic        rreq = 1'b0;

   slave_core_if if_a();
   slave_core_if if_b();
   slave_core_if if_c();

   assign if_a.addr_from_si = addr;
   assign if_b.addr_from_si = addr;
   assign if_c.addr_from_si = addr;
   assign if_a.write_data_from_si = wdata;
   assign if_b.write_data_from_si = wdata;
   assign if_c.write_data_from_si = wdata;
   assign if_a.addr_req_from_si = addr_req && (sel == 0);
   assign if_b.addr_req_from_si = addr_req && (sel == 1);
   assign if_c.addr_req_from_si = addr_req && (sel == 2);
   assign if_a.write_data_req_from_si = wreq && (sel == 0);
   assign if_b.write_data_req_from_si = wreq && (sel == 1);
   assign if_c.write_data_req_from_si = wreq && (sel == 2);
   assign if_a.read_data_req_from_si = rreq && (sel == 0);
   assign if_b.read_data_req_from_si = rreq && (sel == 1);
   assign if_c.read_data_req_from_si = rreq && (sel == 2);

   slave_core #(.SLAVE_ID(2'b01), .MEM_DEPTH(4096), .WAIT_STATES(2))
      u_a (.clk(clk), .reset(reset_n), .si(if_a.slave));
   slave_core #(.SLAVE_ID(2'b01), .MEM_DEPTH(256), .WAIT_STATES(0))
      u_b (.clk(clk), .reset(reset_n), .si(if_b.slave));
   slave_core #(.SLAVE_ID(2'b11), .MEM_DEPTH(4096), .WAIT_STATES(15))
      u_c (.clk(clk), .reset(reset_n), .si(if_c.slave));

   logic       ok, done, busy;
   logic [7:0] rdata;
   always_comb begin
      ok = 1'b0; done = 1'b0; busy = 1'b0; rdata = 8'h00;
      case (sel)
         0: begin ok = if_a.ok_response_to_si; done = if_a.req_done_to_si;
                  busy = if_a.busy_to_si; rdata = if_a.read_data_to_si; end
         1: begin ok = if_b.ok_response_to_si; done = if_b.req_done_to_si;
                  busy = if_b.busy_to_si; rdata = if_b.read_data_to_si; end
         default: begin ok = if_c.ok_response_to_si; done = if_c.req_done_to_si;
                  busy = if_c.busy_to_si; rdata = if_c.read_data_to_si; end
      endcase
   end

   // Reference: per-instance byte arrays plus each instance's configuration
   int         ws_of[3]    = '{2, 0, 15};
   int         depth_of[3] = '{4096, 256, 4096};
   logic [1:0] id_of[3]    = '{2'b01, 2'b01, 2'b11};
   logic [7:0] ref_mem[3][4096];
   bit         ref_wr[3][4096];

   int n_cmp = 0;
   int n_fail = 0;

   function automatic logic [7:0] ref_read(input int s, input int a);
      if (a >= depth_of[s]) return 8'h00;
      return ref_mem[s][a];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic addr_phase(input int s, input logic [15:0] a, input string tag);
      int hold;
      sel = s; addr = a; addr_req = 1'b1;
      @(negedge clk);
      check({tag, "_ok_rise"}, 32'(ok), 32'd1);
      hold = $urandom_range(0, 2);
      repeat (hold) @(negedge clk);
      check({tag, "_ok_held"}, 32'(ok), 32'd1);
      addr_req = 1'b0;
      addr = 16'($urandom);
      @(negedge clk);
      check({tag, "_ok_fall"}, 32'(ok), 32'd0);
      check({tag, "_busy_mid"}, 32'(busy), 32'd1);
   endtask

   task automatic data_phase(input int s, input bit is_wr, input logic [7:0] d,
                             input bit early, input string tag, output logic [7:0] rd);
      int k;
      if (is_wr) begin wdata = d; wreq = 1'b1; end
      else rreq = 1'b1;
      k = 0;
      rd = 8'hxx;
      while (k < 40) begin
         @(negedge clk);
         k++;
         if (early && k == 1) begin wreq = 1'b0; rreq = 1'b0; end
         if (done) break;
      end
      check({tag, "_latency"}, 32'(k), 32'(ws_of[s] + 2));
      rd = rdata;
      wreq = 1'b0; rreq = 1'b0;
      wdata = 8'($urandom);
      @(negedge clk);
      check({tag, "_done_fall"}, 32'(done), 32'd0);
      check({tag, "_busy_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic bus_write(input int s, input int a, input logic [7:0] d,
                            input bit early, input string tag);
      logic [7:0] rd;
      addr_phase(s, {STARTBIT, id_of[s], RW_WRITE, 12'(a)}, tag);
      data_phase(s, 1'b1, d, early, tag, rd);
      if (a < depth_of[s]) begin
         ref_mem[s][a] = d;
         ref_wr[s][a]  = 1'b1;
      end
   endtask

   task automatic bus_read(input int s, input int a, input bit early, input string tag);
      logic [7:0] rd;
      addr_phase(s, {STARTBIT, id_of[s], RW_READ, 12'(a)}, tag);
      data_phase(s, 1'b0, 8'h00, early, tag, rd);
      check({tag, "_data"}, 32'(rd), 32'(ref_read(s, a)));
      check({tag, "_data_held"}, 32'(rdata), 32'(ref_read(s, a)));
   endtask

   initial begin
      bit seen;
      int s, a;
      bit early;

      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         sel = i;
         #1;
         check("reset_ok", 32'(ok), 32'd0);
         check("reset_done", 32'(done), 32'd0);
         check("reset_busy", 32'(busy), 32'd0);
         check("reset_rdata", 32'(rdata), 32'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      bus_write(0, 500, 8'd170, 1'b0, "w500");
      bus_read(0, 500, 1'b0, "r500");

      for (int i = 0; i < 6; i++) bus_write(2, 2000 + i, 8'(180 + 7 * i), 1'b0, "burst_w");
      for (int i = 0; i < 6; i++) bus_read(2, 2000 + i, 1'b0, "burst_r");

      sel = 0; addr = {STARTBIT, SLAVE2, RW_READ, 12'd5}; addr_req = 1'b1;
      seen = 1'b0;
      repeat (50) begin @(negedge clk); if (ok || busy) seen = 1'b1; end
      check("other_id_ignored", 32'(seen), 32'd0);
      addr = {~STARTBIT, SLAVE1, RW_READ, 12'd5}; rreq = 1'b1; wreq = 1'b1;
      repeat (10) begin @(negedge clk); if (ok || busy || done) seen = 1'b1; end
      check("nostart_ignored", 32'(seen), 32'd0);
      addr_req = 1'b0; rreq = 1'b0; wreq = 1'b0;
      @(negedge clk);
      bus_read(0, 500, 1'b0, "after_nomatch");

      bus_write(1, 44, 8'h44, 1'b0, "b_w44");
      bus_read(1, 44, 1'b0, "b_r44_ws0");
      bus_write(1, 300, 8'h55, 1'b0, "b_w300");
      bus_read(1, 300, 1'b0, "b_r300_oor");
      bus_read(1, 44, 1'b0, "b_r44_intact");
      bus_write(2, 7, 8'h3c, 1'b1, "c_w7_early");
      bus_read(2, 7, 1'b0, "c_r7_ws15");

      bus_write(0, 10, 8'h11, 1'b0, "pre_rst_w10");
      addr_phase(0, {STARTBIT, SLAVE1, RW_WRITE, 12'd10}, "rst_w10");
      wdata = 8'hAA; wreq = 1'b1;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("rst_mid_ok", 32'(ok), 32'd0);
      check("rst_mid_done", 32'(done), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      wreq = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      bus_read(0, 10, 1'b0, "post_rst_r10");

      for (int i = 0; i < 30; i++) begin
         s = $urandom_range(0, 2);
         a = $urandom_range(0, 7) * 61 + 200;
         early = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1 && (ref_wr[s][a] || a >= depth_of[s]))
            bus_read(s, a, early, "rnd_r");
         else
            bus_write(s, a, 8'($urandom), early, "rnd_w");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
